conv_layer_scheduler: RTL and testbench
=======================================

// Module: conv_layer_scheduler
// PURPOSE
//  Sequences the conv2d engine across all NUM_NEURONS filters of one layer.
//  Per neuron: streams K=WINDOW_SIZE^2 weights from weight RAM into the engine's weight port, runs the engine, and rebases each output to a global feature-map address.
//  Sits between the layer controller (start/done) and the conv2d engine plus weight/feature-map RAMs.
// PARAMETERS
//  INPUT_WIDTH     64     input plane width
//  INPUT_HEIGHT    64     input plane height
//  WINDOW_SIZE     3      kernel side; K = WINDOW_SIZE^2
//  NUM_NEURONS     30     filters per layer
//  TIMEOUT_CYCLES  2**20  max cycles in RUN per neuron before error
//  derived: OUT_PIX=(INPUT_WIDTH-WINDOW_SIZE+1)*(INPUT_HEIGHT-WINDOW_SIZE+1); LAW=$clog2(OUT_PIX); GAW=$clog2(OUT_PIX*NUM_NEURONS)
// PORTS
//  clk               in   1      clock, rising edge
//  reset_n           in   1      asynchronous, active-low reset
//  layer_start       in   1      start pulse; accepted only in IDLE
//  layer_busy        out  1      high from accept until DONE exit
//  layer_done        out  1      one-cycle pulse at layer end
//  layer_error       out  1      sticky timeout flag; cleared on next accepted start
//  neuron_idx        out  $clog2(NUM_NEURONS)  current filter
//  w_rd_en           out  1      weight RAM read strobe
//  w_rd_addr         out  $clog2(NUM_NEURONS*K)  = neuron_idx*K + k
//  w_rd_data         in   16     weight RAM data, valid 1 cycle after w_rd_en
//  conv_w_wr_en      out  1      engine weight write strobe
//  conv_w_wr_idx     out  $clog2(K)  engine weight slot
//  conv_w_wr_data    out  16     Q8.8 weight
//  conv_enable       out  1      engine enable (level, RUN only)
//  conv_done         in   1      engine completion pulse
//  conv_output_valid in   1      engine output strobe
//  conv_output_addr  in   LAW    engine-local pixel address
//  conv_feature_map  in   16     engine output pixel
//  fm_wr_en          out  1      feature-map RAM write
//  fm_wr_addr        out  GAW    neuron_idx*OUT_PIX + conv_output_addr
//  fm_wr_data        out  16     registered conv_feature_map
// BEHAVIOUR
//  Reset: state IDLE; all outputs, counters, neuron_idx = 0; layer_error = 0. Reset mid-operation aborts immediately; no further RAM writes.
//  States: IDLE -> WLOAD -> WLAST -> RUN -> NEXT -> (WLOAD | DONE) -> IDLE.
//  IDLE: layer_start=1 -> neuron_idx=0, layer_error=0, k=0, WLOAD. layer_start in any other state ignored.
//  WLOAD: K cycles; w_rd_en=1, w_rd_addr=neuron_idx*K+k, k++. Each read's data written next cycle: conv_w_wr_en=1, idx=k-1, data=w_rd_data. After k=K-1 -> WLAST.
//  WLAST: one cycle; final weight write (idx K-1), no read. -> RUN; timeout counter cleared.
//  RUN: conv_enable=1; counter++ each cycle. conv_done=1 -> NEXT. Counter reaching TIMEOUT_CYCLES-1 without conv_done -> layer_error=1, DONE.
//  Output path (RUN only): fm_wr_en/addr/data registered, 1-cycle latency from conv_output_valid. Valid strobes outside RUN dropped. conv_output_valid and conv_done in same cycle: write still issued (occurs in NEXT).
//  Address math: neuron_base = neuron_idx*OUT_PIX, GAW bits, no overflow by construction; conv_output_addr >= OUT_PIX is passed unchecked.
//  NEXT: conv_enable=0. neuron_idx==NUM_NEURONS-1 -> DONE; else neuron_idx++, k=0, WLOAD.
//  DONE: layer_done=1 one cycle, -> IDLE. layer_busy=1 in every state except IDLE.
//  conv_done outside RUN ignored. NUM_NEURONS=1: single WLOAD/RUN pass then DONE.
//  Per neuron (no timeout): K+1 cycles weight load + engine run time + 1 (NEXT).
// TESTING (bench params: INPUT 5x5, WINDOW_SIZE 3, NUM_NEURONS 2, TIMEOUT_CYCLES 64; K=9, OUT_PIX=9)
//  1 Weight load: RAM[i]=i, pulse start -> conv_w_wr idx 0..8 data 0..8 on consecutive cycles, then neuron 1 gets data 9..17 at idx 0..8.
//  2 Rebase: engine model emits addrs 0..8 per neuron -> fm_wr_addr 0..8 then 9..17, 1 cycle after each strobe; layer_done pulses once, busy falls same cycle.
//  3 Timeout: model never asserts conv_done -> layer_error=1 after 64 RUN cycles, layer_done pulse, no neuron 1 load; next start clears error.
//  4 Ignored events: layer_start during RUN, conv_done in WLOAD, conv_output_valid in IDLE -> no state change, no fm_wr_en.
//  5 Simultaneous: last conv_output_valid with conv_done -> write addr 8 still issued, then WLOAD for neuron 1.
//  6 Reset mid-WLOAD (k=4): reset_n low -> all outputs 0 asynchronously; after release, start reloads from k=0.

Source files
------------

// File: rtl/conv_layer_scheduler.sv
// conv_layer_scheduler
//   Walks the conv2d engine through every filter of one layer. For each
//   neuron it copies K weights from the weight RAM into the engine, lets the
//   engine run, and moves every engine output pixel to its global address in
//   the feature-map RAM.
//
// Ports
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   layer_start         start pulse from the layer controller (IDLE only)
//   layer_busy          high in every state except IDLE
//   layer_done          one-cycle pulse at the end of the layer
//   layer_error         sticky run timeout flag, cleared by the next start
//   neuron_idx          filter currently being processed
//   w_rd_en/addr/data   weight RAM read port (data one cycle after enable)
//   conv_w_wr_*         engine weight slot write port
//   conv_enable         engine enable level, high while running
//   conv_done           engine completion pulse
//   conv_output_*       engine output strobe, local address and pixel
//   conv_feature_map    engine output pixel value
//   fm_wr_*             feature-map RAM write port (registered)

module conv_layer_scheduler #(
    parameter int INPUT_WIDTH    = 64,
    parameter int INPUT_HEIGHT   = 64,
    parameter int WINDOW_SIZE    = 3,
    parameter int NUM_NEURONS    = 30,
    parameter int TIMEOUT_CYCLES = 2**20,
    localparam int K       = WINDOW_SIZE * WINDOW_SIZE,
    localparam int OUT_PIX = (INPUT_WIDTH - WINDOW_SIZE + 1) * (INPUT_HEIGHT - WINDOW_SIZE + 1),
    localparam int LAW     = (OUT_PIX > 1) ? $clog2(OUT_PIX) : 1,
    localparam int GAW     = (OUT_PIX * NUM_NEURONS > 1) ? $clog2(OUT_PIX * NUM_NEURONS) : 1,
    localparam int NIW     = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
    localparam int KW      = (K > 1) ? $clog2(K) : 1,
    localparam int WAW     = (NUM_NEURONS * K > 1) ? $clog2(NUM_NEURONS * K) : 1,
    localparam int TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             layer_start,
    output logic             layer_busy,
    output logic             layer_done,
    output logic             layer_error,
    output logic [NIW-1:0]   neuron_idx,
    output logic             w_rd_en,
    output logic [WAW-1:0]   w_rd_addr,
    input  logic [15:0]      w_rd_data,
    output logic             conv_w_wr_en,
    output logic [KW-1:0]    conv_w_wr_idx,
    output logic [15:0]      conv_w_wr_data,
    output logic             conv_enable,
    input  logic             conv_done,
    input  logic             conv_output_valid,
    input  logic [LAW-1:0]   conv_output_addr,
    input  logic [15:0]      conv_feature_map,
    output logic             fm_wr_en,
    output logic [GAW-1:0]   fm_wr_addr,
    output logic [15:0]      fm_wr_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_WLAST,
        S_RUN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t          state, next_state;
    logic [KW-1:0]   k;
    logic [TW-1:0]   run_cnt;

    logic timeout_hit;
    logic last_neuron;
    logic last_k;

    assign timeout_hit = (run_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign last_neuron = (neuron_idx == NIW'(NUM_NEURONS - 1));
    assign last_k      = (k == KW'(K - 1));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control outputs. The weight write trails each read by one
    // cycle because the RAM returns data a cycle late, so slot k-1 is written
    // while address k is being read, and WLAST writes the final slot.
    always_comb begin
        next_state     = state;
        layer_done     = 1'b0;
        w_rd_en        = 1'b0;
        w_rd_addr      = '0;
        conv_w_wr_en   = 1'b0;
        conv_w_wr_idx  = '0;
        conv_enable    = 1'b0;
        layer_busy     = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (layer_start) next_state = S_WLOAD;
            end
            S_WLOAD: begin
                w_rd_en   = 1'b1;
                w_rd_addr = WAW'(neuron_idx) * WAW'(K) + WAW'(k);
                if (k != '0) begin
                    conv_w_wr_en  = 1'b1;
                    conv_w_wr_idx = k - KW'(1);
                end
                if (last_k) next_state = S_WLAST;
            end
            S_WLAST: begin
                conv_w_wr_en  = 1'b1;
                conv_w_wr_idx = KW'(K - 1);
                next_state    = S_RUN;
            end
            S_RUN: begin
                conv_enable = 1'b1;
                if (conv_done)        next_state = S_NEXT;
                else if (timeout_hit) next_state = S_DONE;
            end
            S_NEXT: begin
                next_state = last_neuron ? S_DONE : S_WLOAD;
            end
            S_DONE: begin
                layer_done = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        conv_w_wr_data = conv_w_wr_en ? w_rd_data : 16'h0000;
    end

    // Neuron, weight-slot and run-timeout bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            neuron_idx  <= '0;
            k           <= '0;
            run_cnt     <= '0;
            layer_error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (layer_start) begin
                        neuron_idx  <= '0;
                        k           <= '0;
                        layer_error <= 1'b0;
                    end
                end
                S_WLOAD: begin
                    if (!last_k) k <= k + KW'(1);
                end
                S_WLAST: begin
                    run_cnt <= '0;
                end
                S_RUN: begin
                    run_cnt <= run_cnt + TW'(1);
                    if (!conv_done && timeout_hit) layer_error <= 1'b1;
                end
                S_NEXT: begin
                    if (!last_neuron) begin
                        neuron_idx <= neuron_idx + NIW'(1);
                        k          <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Engine outputs are only accepted while running; a strobe arriving with
    // conv_done is still captured and lands one cycle later in NEXT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fm_wr_en   <= 1'b0;
            fm_wr_addr <= '0;
            fm_wr_data <= '0;
        end else begin
            fm_wr_en <= (state == S_RUN) && conv_output_valid;
            if ((state == S_RUN) && conv_output_valid) begin
                fm_wr_addr <= GAW'(neuron_idx) * GAW'(OUT_PIX) + GAW'(conv_output_addr);
                fm_wr_data <= conv_feature_map;
            end
        end
    end

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// tb_conv_layer_scheduler
//   Directed bench for conv_layer_scheduler with a 5x5 input, 3x3 window,
//   two neurons and a 64-cycle run timeout. A per-cycle vector table covers a
//   complete two-neuron layer; hand-written sequences cover the timeout and an
//   asynchronous reset during weight load.

module tb_conv_layer_scheduler;

    localparam int NCYC = 43;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        layer_start = 1'b0;
    logic        layer_busy, layer_done, layer_error;
    logic [0:0]  neuron_idx;
    logic        w_rd_en;
    logic [4:0]  w_rd_addr;
    logic [15:0] w_rd_data = 16'h0000;
    logic        conv_w_wr_en;
    logic [3:0]  conv_w_wr_idx;
    logic [15:0] conv_w_wr_data;
    logic        conv_enable;
    logic        conv_done = 1'b0;
    logic        conv_output_valid = 1'b0;
    logic [3:0]  conv_output_addr = 4'h0;
    logic [15:0] conv_feature_map = 16'h0000;
    logic        fm_wr_en;
    logic [4:0]  fm_wr_addr;
    logic [15:0] fm_wr_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_cycle = 0;

    logic [15:0] wram [0:17];

    typedef struct {
        logic        start;
        logic        cdone;
        logic        cvalid;
        logic [3:0]  caddr;
        logic [15:0] cfm;
        logic        busy;
        logic        done;
        logic        rd_en;
        logic [4:0]  rd_addr;
        logic        wr_en;
        logic [3:0]  wr_idx;
        logic [15:0] wr_data;
        logic        en;
        logic        fm_en;
        logic [4:0]  fm_addr;
        logic [15:0] fm_data;
        logic        nidx;
    } vec_t;

    vec_t vecs [NCYC];

    conv_layer_scheduler #(
        .INPUT_WIDTH   (5),
        .INPUT_HEIGHT  (5),
        .WINDOW_SIZE   (3),
        .NUM_NEURONS   (2),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .layer_start      (layer_start),
        .layer_busy       (layer_busy),
        .layer_done       (layer_done),
        .layer_error      (layer_error),
        .neuron_idx       (neuron_idx),
        .w_rd_en          (w_rd_en),
        .w_rd_addr        (w_rd_addr),
        .w_rd_data        (w_rd_data),
        .conv_w_wr_en     (conv_w_wr_en),
        .conv_w_wr_idx    (conv_w_wr_idx),
        .conv_w_wr_data   (conv_w_wr_data),
        .conv_enable      (conv_enable),
        .conv_done        (conv_done),
        .conv_output_valid(conv_output_valid),
        .conv_output_addr (conv_output_addr),
        .conv_feature_map (conv_feature_map),
        .fm_wr_en         (fm_wr_en),
        .fm_wr_addr       (fm_wr_addr),
        .fm_wr_data       (fm_wr_data)
    );

    always #5 clk = ~clk;

    // Weight RAM model: one-cycle read latency, contents RAM[i] = i
    always @(posedge clk) begin
        if (w_rd_en) w_rd_data <= wram[w_rd_addr];
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cur_cycle, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        layer_start       = v.start;
        conv_done         = v.cdone;
        conv_output_valid = v.cvalid;
        conv_output_addr  = v.caddr;
        conv_feature_map  = v.cfm;
    endtask

    task automatic clear_inputs();
        layer_start       = 1'b0;
        conv_done         = 1'b0;
        conv_output_valid = 1'b0;
        conv_output_addr  = 4'h0;
        conv_feature_map  = 16'h0000;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Expected per-cycle activity for one full layer. Neuron n starts its
    // weight load at cycle b = 1 + 20n: reads on b..b+8, writes on b+1..b+9
    // (b+9 is WLAST), run on b+10..b+18 with the engine emitting addresses
    // 0..8 and finishing together with the last strobe, NEXT on b+19.
    // Cycle 41 is DONE, cycle 42 is back in IDLE.
    task automatic build_table();
        for (int c = 0; c < NCYC; c++) begin
            vecs[c] = '{start: 1'b0, cdone: 1'b0, cvalid: 1'b0, caddr: 4'h0, cfm: 16'h0,
                        busy: 1'b0, done: 1'b0, rd_en: 1'b0, rd_addr: 5'h0, wr_en: 1'b0,
                        wr_idx: 4'h0, wr_data: 16'h0, en: 1'b0, fm_en: 1'b0,
                        fm_addr: 5'h0, fm_data: 16'h0, nidx: 1'b0};
        end
        vecs[0].start  = 1'b1;
        vecs[0].cvalid = 1'b1;
        vecs[0].caddr  = 4'h3;
        for (int n = 0; n < 2; n++) begin
            int b;
            b = 1 + n * 20;
            for (int c = b; c < b + 20; c++) begin
                vecs[c].busy = 1'b1;
                vecs[c].nidx = n[0];
            end
            for (int j = 0; j < 9; j++) begin
                vecs[b + j].rd_en       = 1'b1;
                vecs[b + j].rd_addr     = 5'(n * 9 + j);
                vecs[b + j + 1].wr_en   = 1'b1;
                vecs[b + j + 1].wr_idx  = 4'(j);
                vecs[b + j + 1].wr_data = 16'(n * 9 + j);
                vecs[b + 10 + j].en     = 1'b1;
                vecs[b + 10 + j].cvalid = 1'b1;
                vecs[b + 10 + j].caddr  = 4'(j);
                vecs[b + 10 + j].cfm    = 16'(256 + n * 16 + j);
                vecs[b + 11 + j].fm_en   = 1'b1;
                vecs[b + 11 + j].fm_addr = 5'(n * 9 + j);
                vecs[b + 11 + j].fm_data = 16'(256 + n * 16 + j);
            end
            vecs[b + 18].cdone = 1'b1;
        end
        // events that must be ignored
        vecs[3].cdone  = 1'b1;
        vecs[13].start = 1'b1;
        vecs[30].cdone = 1'b1;
        vecs[41].busy = 1'b1;
        vecs[41].done = 1'b1;
        vecs[41].nidx = 1'b1;
        vecs[42].nidx = 1'b1;
    endtask

    initial begin
        int rd_seen;
        for (int i = 0; i < 18; i++) wram[i] = 16'(i);
        build_table();

        // reset state
        clear_inputs();
        repeat (2) @(negedge clk);
        cur_cycle = -1;
        check_output("reset_busy",  layer_busy,   0);
        check_output("reset_error", layer_error,  0);
        check_output("reset_rd_en", w_rd_en,      0);
        check_output("reset_fm_en", fm_wr_en,     0);
        check_output("reset_nidx",  neuron_idx,   0);
        reset_n = 1'b1;

        // full two-neuron layer, table driven
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            cur_cycle = c;
            check_output("busy",  layer_busy,   vecs[c].busy);
            check_output("done",  layer_done,   vecs[c].done);
            check_output("error", layer_error,  0);
            check_output("rd_en", w_rd_en,      vecs[c].rd_en);
            check_output("wr_en", conv_w_wr_en, vecs[c].wr_en);
            check_output("en",    conv_enable,  vecs[c].en);
            check_output("fm_en", fm_wr_en,     vecs[c].fm_en);
            check_output("nidx",  neuron_idx,   vecs[c].nidx);
            if (vecs[c].rd_en) check_output("rd_addr", w_rd_addr, vecs[c].rd_addr);
            if (vecs[c].wr_en) begin
                check_output("wr_idx",  conv_w_wr_idx,  vecs[c].wr_idx);
                check_output("wr_data", conv_w_wr_data, vecs[c].wr_data);
            end
            if (vecs[c].fm_en) begin
                check_output("fm_addr", fm_wr_addr, vecs[c].fm_addr);
                check_output("fm_data", fm_wr_data, vecs[c].fm_data);
            end
            apply_stimulus(vecs[c]);
        end
        @(negedge clk);
        clear_inputs();

        // timeout: engine never finishes
        apply_reset();
        @(negedge clk);
        layer_start = 1'b1;
        @(negedge clk);
        layer_start = 1'b0;
        repeat (9) @(negedge clk);
        rd_seen = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            cur_cycle = 100 + c;
            if (w_rd_en) rd_seen++;
            if (c == 0)  check_output("to_run_start_en", conv_enable, 1);
            if (c == 63) begin
                check_output("to_run_last_en",    conv_enable, 1);
                check_output("to_run_last_error", layer_error, 0);
            end
        end
        @(negedge clk);
        cur_cycle = 164;
        if (w_rd_en) rd_seen++;
        check_output("to_done",       layer_done,  1);
        check_output("to_error_set",  layer_error, 1);
        check_output("to_en_off",     conv_enable, 0);
        @(negedge clk);
        cur_cycle = 165;
        if (w_rd_en) rd_seen++;
        check_output("to_idle_busy",  layer_busy,  0);
        check_output("to_error_held", layer_error, 1);
        check_output("to_done_pulse", layer_done,  0);
        check_output("to_nidx",       neuron_idx,  0);
        check_output("to_no_n1_load", rd_seen,     0);
        layer_start = 1'b1;
        @(negedge clk);
        layer_start = 1'b0;
        cur_cycle = 166;
        check_output("restart_error_clr", layer_error, 0);
        check_output("restart_busy",      layer_busy,  1);
        check_output("restart_rd_addr",   w_rd_addr,   0);

        // asynchronous reset in the middle of weight load
        apply_reset();
        @(negedge clk);
        layer_start = 1'b1;
        @(negedge clk);
        layer_start = 1'b0;
        repeat (4) @(negedge clk);
        cur_cycle = 200;
        check_output("mid_k4_rd_addr", w_rd_addr,      4);
        check_output("mid_k4_wr_idx",  conv_w_wr_idx,  3);
        check_output("mid_k4_wr_data", conv_w_wr_data, 3);
        reset_n = 1'b0;
        #1;
        cur_cycle = 201;
        check_output("arst_busy",    layer_busy,     0);
        check_output("arst_rd_en",   w_rd_en,        0);
        check_output("arst_rd_addr", w_rd_addr,      0);
        check_output("arst_wr_en",   conv_w_wr_en,   0);
        check_output("arst_wr_data", conv_w_wr_data, 0);
        check_output("arst_en",      conv_enable,    0);
        check_output("arst_fm_en",   fm_wr_en,       0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        layer_start = 1'b1;
        @(negedge clk);
        layer_start = 1'b0;
        cur_cycle = 202;
        check_output("reload_k0_addr",  w_rd_addr,    0);
        check_output("reload_k0_wr_en", conv_w_wr_en, 0);
        @(negedge clk);
        cur_cycle = 203;
        check_output("reload_k1_addr", w_rd_addr,      1);
        check_output("reload_k1_idx",  conv_w_wr_idx,  0);
        check_output("reload_k1_data", conv_w_wr_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
